ifu_fill_engine: RTL and testbench

- Sits between the instruction cache fill-request port and a 32-bit-wide instruction memory.
- Accepts a line-fill request (address + valid) from the cache and issues CL_WIDTH/WORD_WIDTH sequential word reads over a ready/valid memory port.
- Assembles the words into one cache line and returns it with a one-cycle valid pulse and the line-aligned address.

---
 rtl/ifu_fill_engine_if.sv | 32 +++
 rtl/ifu_fill_engine.sv | 132 +++++++++++++
 tb/tb_ifu_fill_engine.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fill_engine_if.sv
// Bundle between ifu_fill_engine and its cache-side and memory-side neighbours.
// slave: the fill engine's view. master: the cache plus instruction-memory view.
interface ifu_fill_engine_if #(
   parameter int CL_WIDTH   = 128,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] fill_req_addr;
   logic                  fill_req_valid;
   logic [CL_WIDTH-1:0]   fill_rsp_line;
   logic [ADDR_WIDTH-1:0] fill_rsp_addr;
   logic                  fill_rsp_valid;
   logic                  busy;
   logic                  mem_rd_req;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic                  mem_rd_ready;
   logic                  mem_rd_rsp_valid;
   logic [WORD_WIDTH-1:0] mem_rd_rsp_data;
   logic                  spurious_rsp;

   modport slave (
      input  fill_req_addr, fill_req_valid, mem_rd_ready, mem_rd_rsp_valid, mem_rd_rsp_data,
      output fill_rsp_line, fill_rsp_addr, fill_rsp_valid, busy, mem_rd_req, mem_rd_addr,
             spurious_rsp
   );

   modport master (
      output fill_req_addr, fill_req_valid, mem_rd_ready, mem_rd_rsp_valid, mem_rd_rsp_data,
      input  fill_rsp_line, fill_rsp_addr, fill_rsp_valid, busy, mem_rd_req, mem_rd_addr,
             spurious_rsp
   );
endinterface

// File: rtl/ifu_fill_engine.sv
// Cache line fill engine: one outstanding word read at a time, line assembled and returned
// with a one-cycle valid. Define IFU_FILL_CWF_EN to issue the critical word first.
//
// state   | meaning
// S_IDLE  | waiting for a fill request; captures the line address
// S_ISSUE | word read request held on the memory port until accepted
// S_WAIT  | request accepted, waiting for its read data
// S_RSP   | assembled line presented with fill_rsp_valid for one cycle
module ifu_fill_engine #(
   parameter int CL_WIDTH   = 128,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   ifu_fill_engine_if.slave   bus
);
   localparam int WORDS = CL_WIDTH / WORD_WIDTH;
   localparam int OFF   = $clog2(CL_WIDTH / 8);
   localparam int WB    = $clog2(WORD_WIDTH / 8);
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((CL_WIDTH / 8) - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RSP} state_t;

   state_t                         state_q, state_d;
   logic [IDX_W-1:0]               cnt_q;
   logic [IDX_W-1:0]               start_off;
   logic [IDX_W-1:0]               idx;
   logic [ADDR_WIDTH-1:0]          line_addr_q;
   logic [ADDR_WIDTH-1:0]          rsp_addr_q;
   logic [WORDS-1:0][WORD_WIDTH-1:0] line_buf_q, line_buf_d;
   logic [CL_WIDTH-1:0]            rsp_line_q;
   logic                           spurious_q;
   logic                           rsp_take;
   logic                           last_word;

`ifdef IFU_FILL_CWF_EN
   logic [IDX_W-1:0] start_off_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_off_q <= '0;
      end else if (state_q == S_IDLE && bus.fill_req_valid) begin
         start_off_q <= bus.fill_req_addr[OFF-1:WB];
      end
   end

   assign start_off = start_off_q;
`else
   assign start_off = '0;
`endif

   // Power-of-two WORDS makes the natural adder wrap the modulo.
   assign idx       = cnt_q + start_off;
   assign last_word = (cnt_q == IDX_W'(WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rsp_take = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.fill_req_valid) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (bus.mem_rd_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.mem_rd_rsp_valid) begin
               rsp_take = 1'b1;
               state_d  = last_word ? S_RSP : S_ISSUE;
            end
         end
         S_RSP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      line_buf_d      = line_buf_q;
      line_buf_d[idx] = bus.mem_rd_rsp_data;
   end

   // Output line/address live in their own registers so they only change when a new line is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         line_addr_q <= '0;
         line_buf_q  <= '0;
         rsp_line_q  <= '0;
         rsp_addr_q  <= '0;
         spurious_q  <= 1'b0;
      end else begin
         if (state_q == S_IDLE && bus.fill_req_valid) begin
            line_addr_q <= bus.fill_req_addr & ~OFF_MASK;
            cnt_q       <= '0;
         end
         if (rsp_take) begin
            line_buf_q <= line_buf_d;
            if (last_word) begin
               rsp_line_q <= line_buf_d;
               rsp_addr_q <= line_addr_q;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
         if (bus.mem_rd_rsp_valid && state_q != S_WAIT) begin
            spurious_q <= 1'b1;
         end
      end
   end

   assign bus.mem_rd_req     = (state_q == S_ISSUE);
   assign bus.mem_rd_addr    = (state_q == S_ISSUE) ? (line_addr_q | (ADDR_WIDTH'(idx) << WB)) : '0;
   assign bus.fill_rsp_valid = (state_q == S_RSP);
   assign bus.fill_rsp_line  = rsp_line_q;
   assign bus.fill_rsp_addr  = rsp_addr_q;
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.spurious_rsp   = spurious_q;
endmodule

// File: tb/tb_ifu_fill_engine.sv
// Directed bench for ifu_fill_engine: vector table of fills plus hand sequences for
// spurious responses, ignored requests and reset in the middle of a fill.
module tb_ifu_fill_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ifu_fill_engine_if #(.CL_WIDTH(128), .WORD_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   ifu_fill_engine #(.CL_WIDTH(128), .WORD_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   localparam logic [31:0] NO_STALL = 32'h0000_0001;

   int n_chk  = 0;
   int n_fail = 0;

   // memory model state
   logic [31:0] acc_log [0:255];
   int          acc_n = 0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          stall_done = 0;
   logic [31:0] stall_addr = NO_STALL;
   int          stall_len = 0;
   logic        inj_valid = 1'b0;
   logic [31:0] inj_data = '0;

   typedef struct {
      logic [31:0]  addr;
      logic [31:0]  stall_addr;
      int           stall_len;
      int           exp_lat;
      logic [31:0]  exp_addr;
      logic [127:0] exp_line;
   } vec_t;

   vec_t vecs [5];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:4] == 28'h0000100) return 32'h0000_00A0 + 32'(a[3:2]);
      return {a[15:0], 8'h00, 8'hC0 + {6'h0, a[3:2]}};
   endfunction

   // One-cycle memory: accepts when ready, returns data the cycle after accept.
   always @(negedge clk) begin
      if (!rst_n) begin
         pend                 = 1'b0;
         stall_done           = 0;
         bus.mem_rd_ready     = 1'b1;
         bus.mem_rd_rsp_valid = 1'b0;
         bus.mem_rd_rsp_data  = '0;
      end else begin
         bus.mem_rd_rsp_valid = pend | inj_valid;
         bus.mem_rd_rsp_data  = pend ? mem_word(pend_addr) : (inj_valid ? inj_data : 32'h0);
         if (bus.mem_rd_req && bus.mem_rd_addr == stall_addr && stall_done < stall_len) begin
            bus.mem_rd_ready = 1'b0;
            stall_done++;
         end else begin
            bus.mem_rd_ready = 1'b1;
         end
         if (!bus.mem_rd_req) stall_done = 0;
         pend = bus.mem_rd_req && bus.mem_rd_ready;
         if (pend) begin
            pend_addr = bus.mem_rd_addr;
            if (acc_n < 256) acc_log[acc_n] = bus.mem_rd_addr;
            acc_n++;
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_fill(input vec_t v, input string tag, input logic [31:0] alt_addr, input int alt_at);
      int           base;
      int           lat;
      int           stall_seen;
      logic         busy_ok;
      logic [127:0] line;
      logic [31:0]  raddr;
      logic [127:0] got_ord;
      logic [127:0] exp_ord;
      logic [1:0]   s;
      lat        = 0;
      stall_seen = 0;
      busy_ok    = 1'b1;
      line       = '0;
      raddr      = '0;
      @(negedge clk); #1;
      base       = acc_n;
      stall_addr = v.stall_addr;
      stall_len  = v.stall_len;
      bus.fill_req_addr  = v.addr;
      bus.fill_req_valid = 1'b1;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk); #1;
         if (i == alt_at) bus.fill_req_addr = alt_addr;
         if (!bus.busy) busy_ok = 1'b0;
         if (bus.mem_rd_req && !bus.mem_rd_ready && bus.mem_rd_addr == v.stall_addr) stall_seen++;
         if (bus.fill_rsp_valid) begin
            lat   = i;
            line  = bus.fill_rsp_line;
            raddr = bus.fill_rsp_addr;
            break;
         end
      end
      bus.fill_req_valid = 1'b0;
      stall_addr = NO_STALL;
      chk({tag, " latency"}, 128'(lat), 128'(v.exp_lat));
      chk({tag, " rsp_addr"}, 128'(raddr), 128'(v.exp_addr));
      chk({tag, " rsp_line"}, line, v.exp_line);
      chk({tag, " stall_cycles"}, 128'(stall_seen), 128'(v.stall_len));
      chk({tag, " busy_during_fill"}, 128'(busy_ok), 128'(1));
`ifdef IFU_FILL_CWF_EN
      s = v.addr[3:2];
`else
      s = 2'd0;
`endif
      got_ord = '0;
      exp_ord = '0;
      for (int i = 0; i < 4; i++) begin
         if (base + i < 256) got_ord[32*i +: 32] = acc_log[base + i];
         exp_ord[32*i +: 32] = v.exp_addr + {28'h0, s + 2'(i), 2'b00};
      end
      chk({tag, " read_order"}, got_ord, exp_ord);
      chk({tag, " read_count"}, 128'(acc_n - base), 128'(4));
      @(negedge clk); #1;
      chk({tag, " rsp_pulse_width"}, 128'(bus.fill_rsp_valid), 128'(0));
      chk({tag, " busy_after"}, 128'(bus.busy), 128'(0));
      chk({tag, " line_held"}, bus.fill_rsp_line, v.exp_line);
   endtask

   initial begin
      int   found;
      int   base;
      vec_t v4000;

      vecs[0] = '{32'h0000_1000, NO_STALL,     0, 9,  32'h0000_1000,
                  128'h000000A3_000000A2_000000A1_000000A0};
      vecs[1] = '{32'h0000_200E, NO_STALL,     0, 9,  32'h0000_2000,
                  128'h200C00C3_200800C2_200400C1_200000C0};
      vecs[2] = '{32'h0000_1000, 32'h0000_1004, 3, 12, 32'h0000_1000,
                  128'h000000A3_000000A2_000000A1_000000A0};
      vecs[3] = '{32'h0000_5FFC, 32'h0000_5FF0, 1, 10, 32'h0000_5FF0,
                  128'h5FFC00C3_5FF800C2_5FF400C1_5FF000C0};
      vecs[4] = '{32'hFFFF_FFF7, NO_STALL,     0, 9,  32'hFFFF_FFF0,
                  128'hFFFC00C3_FFF800C2_FFF400C1_FFF000C0};
      v4000   = '{32'h0000_4000, NO_STALL,     0, 9,  32'h0000_4000,
                  128'h400C00C3_400800C2_400400C1_400000C0};

      bus.fill_req_addr  = '0;
      bus.fill_req_valid = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("reset mem_rd_req", 128'(bus.mem_rd_req), 128'(0));
      chk("reset mem_rd_addr", 128'(bus.mem_rd_addr), 128'(0));
      chk("reset busy", 128'(bus.busy), 128'(0));
      chk("reset fill_rsp_valid", 128'(bus.fill_rsp_valid), 128'(0));
      chk("reset fill_rsp_line", bus.fill_rsp_line, 128'(0));
      chk("reset fill_rsp_addr", 128'(bus.fill_rsp_addr), 128'(0));
      chk("reset spurious_rsp", 128'(bus.spurious_rsp), 128'(0));
      rst_n = 1'b1;

      for (int k = 0; k < 5; k++) begin
         run_fill(vecs[k], $sformatf("vec%0d", k), 32'h0, 0);
      end

      // spurious response while idle
      @(negedge clk); #1;
      inj_data  = 32'h0000_DEAD;
      inj_valid = 1'b1;
      @(negedge clk); #1;
      inj_valid = 1'b0;
      @(negedge clk); #1;
      chk("spurious set", 128'(bus.spurious_rsp), 128'(1));
      chk("spurious busy", 128'(bus.busy), 128'(0));
      run_fill(vecs[0], "after_spurious", 32'h0, 0);
      chk("spurious sticky", 128'(bus.spurious_rsp), 128'(1));

      // request address changes to 0x3000 while a fill of 0x1000 is in flight
      run_fill(vecs[0], "ignored_req", 32'h0000_3000, 3);
      @(negedge clk); #1;
      chk("ignored no_restart", 128'(bus.mem_rd_req), 128'(0));

      // reset during the wait for word 2
      @(negedge clk); #1;
      base = acc_n;
      bus.fill_req_addr  = 32'h0000_1000;
      bus.fill_req_valid = 1'b1;
      found = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); #1;
         if (acc_n == base + 3 && !bus.mem_rd_req && bus.busy) begin
            found = 1;
            break;
         end
      end
      chk("midreset reached_wait2", 128'(found), 128'(1));
      rst_n = 1'b0;
      bus.fill_req_valid = 1'b0;
      #1;
      chk("midreset mem_rd_req", 128'(bus.mem_rd_req), 128'(0));
      chk("midreset busy", 128'(bus.busy), 128'(0));
      chk("midreset fill_rsp_valid", 128'(bus.fill_rsp_valid), 128'(0));
      chk("midreset spurious_cleared", 128'(bus.spurious_rsp), 128'(0));
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("postreset idle", 128'(bus.busy), 128'(0));
      chk("postreset no_rsp", 128'(bus.fill_rsp_valid), 128'(0));
      run_fill(v4000, "after_reset", 32'h0, 0);
      chk("postreset spurious", 128'(bus.spurious_rsp), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "watchdog expired");
   end
endmodule
